// File: rtl/mux_input_conditioner.sv
// mux_input_conditioner
// Conditions the raw pad controls for the 2:1 selector. Each control is
// synchronised, then sel/d0/d1 are debounced. An auto-toggle mode can drive
// sel at a programmable dwell rate. sel_changed pulses for one cycle on
// every change of sel. All outputs come straight from flops.
module mux_input_conditioner #(
    parameter int SYNC_STAGES     = 2,   // legal 2..4
    parameter int DEBOUNCE_CYCLES = 16,  // legal 2..255
    parameter int DWELL_W         = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic               raw_sel,
    input  logic               raw_d0,
    input  logic               raw_d1,
    input  logic               auto_en,
    input  logic [DWELL_W-1:0] dwell,
    output logic               sel,
    output logic               d0,
    output logic               d1,
    output logic               sel_changed
);

    typedef enum logic {
        MANUAL = 1'b0,
        AUTO   = 1'b1
    } state_t;

    // Channel indices; the auto_en synchroniser sits in slot 3 and is not debounced.
    localparam int CH_SEL  = 0;
    localparam int CH_D0   = 1;
    localparam int CH_D1   = 2;
    localparam int CH_AUTO = 3;

    localparam logic [7:0] DB_LAST = 8'(DEBOUNCE_CYCLES - 1);

    logic [3:0]             raw_vec;
    logic [SYNC_STAGES-1:0] sync_q [4];
    logic [2:0]             synced;
    logic                   auto_sync;

    logic [2:0]             stable_q;
    logic [2:0]             stable_d;
    logic [7:0]             db_cnt_q [3];
    logic [7:0]             db_cnt_d [3];

    state_t                 state_q;
    logic [DWELL_W-1:0]     dwell_cnt_q;

    assign raw_vec   = {auto_en, raw_d1, raw_d0, raw_sel};
    assign synced    = {sync_q[CH_D1][SYNC_STAGES-1],
                        sync_q[CH_D0][SYNC_STAGES-1],
                        sync_q[CH_SEL][SYNC_STAGES-1]};
    assign auto_sync = sync_q[CH_AUTO][SYNC_STAGES-1];

    assign d0 = stable_q[CH_D0];
    assign d1 = stable_q[CH_D1];

    // Synchroniser chains: free-running, independent of ena.
    // NOTE: synchroniser flops are reset too, so no stale pad level can
    // ripple into the debouncers after reset is released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) sync_q[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++)
                sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], raw_vec[i]};
        end
    end

    // Debounce next-state: count while synced differs, adopt after the full run.
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            stable_d[i] = stable_q[i];
            db_cnt_d[i] = db_cnt_q[i];
            if (synced[i] != stable_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    stable_d[i] = synced[i];
                    db_cnt_d[i] = '0;
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 8'd1;
                end
            end else begin
                db_cnt_d[i] = '0;
            end
        end
    end

    // Debounce registers: advance only while enabled.
    // NOTE: state is written with non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_q <= '0;
            for (int i = 0; i < 3; i++) db_cnt_q[i] <= '0;
        end else if (ena) begin
            stable_q <= stable_d;
            for (int i = 0; i < 3; i++) db_cnt_q[i] <= db_cnt_d[i];
        end
    end

    // Select FSM: manual tracking of the debounced select, or auto-toggle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= MANUAL;
            dwell_cnt_q <= '0;
            sel         <= 1'b0;
            sel_changed <= 1'b0;
        end else if (!ena) begin
            sel_changed <= 1'b0;
        end else begin
            case (state_q)
                MANUAL: begin
                    if (auto_sync) begin
                        // Enter auto holding the current select level.
                        state_q     <= AUTO;
                        dwell_cnt_q <= dwell;
                        sel_changed <= 1'b0;
                    end else begin
                        sel         <= stable_d[CH_SEL];
                        sel_changed <= (stable_d[CH_SEL] != sel);
                    end
                end
                AUTO: begin
                    if (!auto_sync) begin
                        // Exit has priority over a toggle due on the same edge.
                        state_q     <= MANUAL;
                        dwell_cnt_q <= '0;
                        sel         <= stable_d[CH_SEL];
                        sel_changed <= (stable_d[CH_SEL] != sel);
                    end else if (dwell_cnt_q == '0) begin
                        sel         <= ~sel;
                        sel_changed <= 1'b1;
                        dwell_cnt_q <= dwell;
                    end else begin
                        dwell_cnt_q <= dwell_cnt_q - DWELL_W'(1);
                        sel_changed <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= MANUAL;
                    sel_changed <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_input_conditioner.sv
// Testbench for mux_input_conditioner (default parameters).
// Each scenario task drives inputs one cycle at a time, pushes the output
// vector {sel, d0, d1, sel_changed} expected after the next rising edge onto
// a scoreboard queue, then pops and compares it 1 ns after that edge.
module tb_mux_input_conditioner;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic       raw_sel;
    logic       raw_d0;
    logic       raw_d1;
    logic       auto_en;
    logic [7:0] dwell;
    logic       sel;
    logic       d0;
    logic       d1;
    logic       sel_changed;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] v;
        string      tag;
        int         idx;
    } exp_t;

    exp_t exp_q[$];

    mux_input_conditioner #(
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(16),
        .DWELL_W        (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .raw_sel    (raw_sel),
        .raw_d0     (raw_d0),
        .raw_d1     (raw_d1),
        .auto_en    (auto_en),
        .dwell      (dwell),
        .sel        (sel),
        .d0         (d0),
        .d1         (d1),
        .sel_changed(sel_changed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic s, input logic a, input logic b,
                            input logic c, input string tag, input int idx);
        exp_t e;
        e.v   = {s, a, b, c};
        e.tag = tag;
        e.idx = idx;
        exp_q.push_back(e);
    endtask

    // Async assertion with no clock edge, then zeros after release.
    task automatic test_reset();
        exp_t e;
        rst_n = 1'b1; ena = 1'b1; raw_sel = 1'b0; raw_d0 = 1'b0; raw_d1 = 1'b0;
        auto_en = 1'b0; dwell = 8'd0;
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({sel, d0, d1, sel_changed} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_async got %b want 0000", {sel, d0, d1, sel_changed});
        end
        tick();
        rst_n = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            push_exp(1'b0, 1'b0, 1'b0, 1'b0, "reset_release", k);
            tick();
            e = exp_q.pop_front();
            checks++;
            if ({sel, d0, d1, sel_changed} !== e.v) begin
                errors++;
                $display("FAIL %s[%0d] got %b want %b", e.tag, e.idx, {sel, d0, d1, sel_changed}, e.v);
            end
        end
    endtask

    // Clean step on raw_d1: d1 rises on the 18th edge, counting the first sampling edge.
    task automatic test_debounce_step();
        exp_t e;
        for (int k = 1; k <= 20; k++) begin
            raw_d1 = 1'b1;
            push_exp(1'b0, 1'b0, (k >= 18), 1'b0, "d1_step", k);
            tick();
            e = exp_q.pop_front();
            checks++;
            if ({sel, d0, d1, sel_changed} !== e.v) begin
                errors++;
                $display("FAIL %s[%0d] got %b want %b", e.tag, e.idx, {sel, d0, d1, sel_changed}, e.v);
            end
        end
    endtask

    // 15-cycle raw_d0 pulse is too short to pass.
    task automatic test_short_pulse();
        exp_t e;
        for (int k = 1; k <= 40; k++) begin
            raw_d0 = (k <= 15);
            push_exp(1'b0, 1'b0, 1'b1, 1'b0, "d0_short", k);
            tick();
            e = exp_q.pop_front();
            checks++;
            if ({sel, d0, d1, sel_changed} !== e.v) begin
                errors++;
                $display("FAIL %s[%0d] got %b want %b", e.tag, e.idx, {sel, d0, d1, sel_changed}, e.v);
            end
        end
    endtask

    // 16-cycle raw_d0 pulse gives a 16-cycle d0 pulse, 18 edges late.
    task automatic test_min_pulse();
        exp_t e;
        for (int k = 1; k <= 40; k++) begin
            raw_d0 = (k <= 16);
            push_exp(1'b0, (k >= 18 && k <= 33), 1'b1, 1'b0, "d0_min", k);
            tick();
            e = exp_q.pop_front();
            checks++;
            if ({sel, d0, d1, sel_changed} !== e.v) begin
                errors++;
                $display("FAIL %s[%0d] got %b want %b", e.tag, e.idx, {sel, d0, d1, sel_changed}, e.v);
            end
        end
    endtask

    // raw_sel high 10, low 1, high: count restarts, sel rises 16 counting
    // edges after the synced return (edge 29 here), one sel_changed pulse.
    task automatic test_glitch_restart();
        exp_t e;
        int   pulses = 0;
        for (int k = 1; k <= 35; k++) begin
            raw_sel = (k != 11);
            push_exp((k >= 29), 1'b0, 1'b1, (k == 29), "sel_glitch", k);
            tick();
            if (sel_changed === 1'b1) pulses++;
            e = exp_q.pop_front();
            checks++;
            if ({sel, d0, d1, sel_changed} !== e.v) begin
                errors++;
                $display("FAIL %s[%0d] got %b want %b", e.tag, e.idx, {sel, d0, d1, sel_changed}, e.v);
            end
        end
        checks++;
        if (pulses !== 1) begin
            errors++;
            $display("FAIL sel_glitch_pulses got %0d want 1", pulses);
        end
    endtask

    // dwell=3: entry on edge 3 keeps sel=1, toggles at 7, 11, 15 ...;
    // raw_sel dropped to 0 must not affect sel.
    task automatic test_auto_mode();
        exp_t e;
        logic s;
        for (int k = 1; k <= 30; k++) begin
            auto_en = 1'b1; raw_sel = 1'b0; dwell = 8'd3;
            s = (k < 7) ? 1'b1 : ((((k - 3) / 4) % 2) == 0);
            push_exp(s, 1'b0, 1'b1, (k >= 7 && ((k - 3) % 4) == 0), "auto_dw3", k);
            tick();
            e = exp_q.pop_front();
            checks++;
            if ({sel, d0, d1, sel_changed} !== e.v) begin
                errors++;
                $display("FAIL %s[%0d] got %b want %b", e.tag, e.idx, {sel, d0, d1, sel_changed}, e.v);
            end
        end
    endtask

    // ena low for 20 cycles mid-AUTO and mid-debounce (raw_d0 rising):
    // behaviour is the un-frozen sequence with those 20 cycles removed.
    task automatic test_ena_freeze();
        exp_t e;
        int   n;
        logic s;
        for (int j = 1; j <= 42; j++) begin
            raw_d0 = 1'b1;
            ena    = !(j >= 7 && j <= 26);
            n      = (j <= 6) ? j : (j <= 26) ? 6 : j - 20;
            s      = ((((n + 3) / 4) % 2) == 0);
            push_exp(s, (n >= 18), 1'b1, (ena && (n % 4) == 1), "ena_freeze", j);
            tick();
            e = exp_q.pop_front();
            checks++;
            if ({sel, d0, d1, sel_changed} !== e.v) begin
                errors++;
                $display("FAIL %s[%0d] got %b want %b", e.tag, e.idx, {sel, d0, d1, sel_changed}, e.v);
            end
        end
        ena = 1'b1;
    endtask

    // dwell=0 toggles every cycle from the next reload; auto_en dropped at
    // cycle 21 exits on edge 23 where a toggle would also be due (sel 1 -> 0);
    // exit wins and sel takes debounced raw_sel = 1 with no change pulse.
    task automatic test_auto_exit();
        exp_t e;
        logic s;
        for (int i = 1; i <= 30; i++) begin
            raw_sel = 1'b1; dwell = 8'd0;
            auto_en = (i <= 20);
            s = (i <= 2) ? 1'b1 : (i <= 22) ? ((i % 2) == 0) : 1'b1;
            push_exp(s, 1'b1, 1'b1, (i >= 3 && i <= 22), "auto_exit", i);
            tick();
            e = exp_q.pop_front();
            checks++;
            if ({sel, d0, d1, sel_changed} !== e.v) begin
                errors++;
                $display("FAIL %s[%0d] got %b want %b", e.tag, e.idx, {sel, d0, d1, sel_changed}, e.v);
            end
        end
    endtask

    // Mid-run reset with sel=1 and the d1 debouncer partway through a count.
    task automatic test_async_reset();
        exp_t e;
        for (int i = 1; i <= 5; i++) begin
            raw_d1 = 1'b0;
            push_exp(1'b1, 1'b1, 1'b1, 1'b0, "pre_reset", i);
            tick();
            e = exp_q.pop_front();
            checks++;
            if ({sel, d0, d1, sel_changed} !== e.v) begin
                errors++;
                $display("FAIL %s[%0d] got %b want %b", e.tag, e.idx, {sel, d0, d1, sel_changed}, e.v);
            end
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({sel, d0, d1, sel_changed} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_mid got %b want 0000", {sel, d0, d1, sel_changed});
        end
        raw_sel = 1'b0; raw_d0 = 1'b0; raw_d1 = 1'b0; auto_en = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 1; i <= 25; i++) begin
            push_exp(1'b0, 1'b0, 1'b0, 1'b0, "post_reset", i);
            tick();
            e = exp_q.pop_front();
            checks++;
            if ({sel, d0, d1, sel_changed} !== e.v) begin
                errors++;
                $display("FAIL %s[%0d] got %b want %b", e.tag, e.idx, {sel, d0, d1, sel_changed}, e.v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_debounce_step();
        test_short_pulse();
        test_min_pulse();
        test_glitch_restart();
        test_auto_mode();
        test_ena_freeze();
        test_auto_exit();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mux_input_conditioner.md
# mux_input_conditioner

Upstream conditioning stage for the 2:1 selector datapath. Takes the three raw pad-level controls (select, data 0, data 1) from the dedicated inputs, synchronises and debounces each, and presents clean registered levels to the selector. Also provides an auto-toggle mode in which the select line alternates at a programmable dwell rate, so the selector can be exercised on silicon without manual switching. A one-cycle strobe marks every select change.

## Interface
Parameters:
- SYNC_STAGES, 2, flops in each input synchroniser (legal 2..4)
- DEBOUNCE_CYCLES, 16, consecutive stable cycles required before a debounced level changes (legal 2..255)
- DWELL_W, 8, width of the dwell-count input

Ports:
- clk  in  1  single clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- ena  in  1  high = block runs; low = all state except the synchronisers holds
- raw_sel  in  1  raw select from pad
- raw_d0  in  1  raw data-0 from pad
- raw_d1  in  1  raw data-1 from pad
- auto_en  in  1  raw pad; high selects auto-toggle mode (synchronised, not debounced)
- dwell  in  DWELL_W  auto-mode hold length; quasi-static, sampled only at reload
- sel  out  1  conditioned select to the selector
- d0  out  1  conditioned data-0
- d1  out  1  conditioned data-1
- sel_changed  out  1  one-cycle pulse, high in the first cycle sel shows a new value

## Operation
- Reset (rst_n low, asynchronous): all synchroniser flops, debounced levels, counters, sel, d0, d1, sel_changed = 0; FSM = MANUAL. Release is synchronous to the next clk edge.
- Synchronisers: raw_sel, raw_d0, raw_d1, auto_en each pass through SYNC_STAGES flops. They run regardless of ena.
- Debounce (per channel sel/d0/d1, independent 8-bit counter):
  - synced != stable: counter increments.
  - Counter reaches DEBOUNCE_CYCLES-1 and synced still != stable: stable takes synced on that edge, counter clears.
  - synced == stable: counter clears (glitch rejection).
  - d0 and d1 outputs are the debounced levels directly.
- Select FSM, states MANUAL, AUTO:
  - MANUAL: sel = debounced select. Synced auto_en = 1 -> AUTO; sel keeps its current value; dwell counter loads dwell.
  - AUTO: dwell counter decrements each enabled cycle. At 0: sel inverts, counter reloads dwell. Hold time per phase = dwell+1 cycles; dwell = 0 toggles every cycle. Debounced select is ignored but its debouncer keeps running.
  - AUTO, synced auto_en = 0 -> MANUAL on next edge; sel takes the debounced select on that same edge. Dwell counter clears.
  - Auto_en falls on the same edge the counter reaches 0: the exit wins and no toggle occurs.
- sel_changed: registered as (sel_next != sel) on the edge where sel updates. It is never high for two consecutive cycles unless sel changes on consecutive cycles (auto mode, dwell = 0).
- ena low: debounce counters, stable levels, FSM, dwell counter, sel, d0, d1 hold. sel_changed = 0. Synchronisers continue. When ena rises, operation resumes from the held state.

## Timing
- Data path latency from a clean raw step to d0/d1/sel (MANUAL mode): SYNC_STAGES + DEBOUNCE_CYCLES cycles. Defaults: 2 + 16 = 18 edges after the first sampling edge.
- A pulse shorter than DEBOUNCE_CYCLES synced cycles never reaches the outputs.
- auto_en to FSM entry or exit: SYNC_STAGES + 1 edges.
- In AUTO, the first toggle occurs dwell+1 cycles after entry. The period is 2*(dwell+1).
- All outputs come directly from flops, with no combinational path from inputs to outputs.

## Test plan
- Reset: assert rst_n = 0 mid-run with sel = 1 and a counter partway. Required: all outputs read 0 immediately, without waiting for clk. After release, with raw inputs at 0, the outputs stay 0.
- Debounce: raw_d1 step 0->1 held. Required: d1 rises exactly 18 edges later (defaults). A 15-cycle raw_d0 pulse leaves d0 = 0. A 16-cycle pulse produces a 16-cycle d0 pulse.
- Glitch restart: raw_sel held high for 10 cycles, low for 1 cycle, then high. Required: sel rises 16 cycles after the return, not earlier. sel_changed pulses once.
- Auto mode: dwell = 3, auto_en = 1. Required: sel toggles every 4 cycles, with a period of 8. sel_changed pulses on each toggle. The debounced raw_sel is ignored.
- Auto exit and edge case: dwell = 0. Required: sel toggles every cycle. Drop auto_en with raw_sel = 1. Required: sel = 1 on the exit edge, with no extra toggle when exit coincides with a 0 count.
- ena freeze: drop ena for 20 cycles during both a debounce count and AUTO. Required: the outputs and counts hold, and sel_changed = 0. When ena rises, counting resumes from the held values.
